// File: rtl/mpc_rd_mux_pkt.sv
// mpc_rd_mux_pkt: packet-aware N:1 read-data mux for one multiport-cache output port.
// A select request locks onto one source port. It only changes between packets;
// a request that arrives mid-packet is held in a one-deep pending register.
// Forwarded beats are registered with a latency of one cycle.
// Ports:
//   i_clk, i_rst_n           clock, async active-low reset
//   i_en                     block enable; 0 flushes every register to its reset value
//   i_sel, i_sel_vld         requested source port and its 1-cycle strobe
//   i_rd_sop/eop/vld/data    per-port read beats; port p data at [p*DATA_W +: DATA_W]
//   o_rd_sop/eop/vld/data    registered output beat
//   o_sel, o_busy            locked port, and 1 while armed or transferring
//   o_timeout, o_proto_err   1-cycle pulses: arm expired / protocol violation on locked port
module mpc_rd_mux_pkt #(
    parameter int unsigned N_PORTS = 16,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned SEL_W   = $clog2(N_PORTS)
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_en,
    input  logic [SEL_W-1:0]            i_sel,
    input  logic                        i_sel_vld,
    input  logic [N_PORTS-1:0]          i_rd_sop,
    input  logic [N_PORTS-1:0]          i_rd_eop,
    input  logic [N_PORTS-1:0]          i_rd_vld,
    input  logic [N_PORTS*DATA_W-1:0]   i_rd_data,
    output logic                        o_rd_sop,
    output logic                        o_rd_eop,
    output logic                        o_rd_vld,
    output logic [DATA_W-1:0]           o_rd_data,
    output logic [SEL_W-1:0]            o_sel,
    output logic                        o_busy,
    output logic                        o_timeout,
    output logic                        o_proto_err
);

    localparam int unsigned      TMR_W    = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_XFER  = 2'd2
    } state_t;

    state_t             r_state;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   r_pend;
    logic               r_pend_vld;
    logic [TMR_W-1:0]   r_timer;
    logic               r_busy;

    state_t             w_state_nxt;
    logic [SEL_W-1:0]   w_sel_nxt;
    logic [SEL_W-1:0]   w_pend_nxt;
    logic               w_pend_vld_nxt;
    logic [TMR_W-1:0]   w_timer_nxt;
    logic               w_fwd;
    logic               w_fwd_sop;
    logic               w_fwd_eop;
    logic               w_perr;
    logic               w_tmo;
    logic               w_close;

    logic [DATA_W-1:0]  w_port_data [N_PORTS];
    logic               w_beat_vld;
    logic               w_beat_sop;
    logic               w_beat_eop;
    logic [DATA_W-1:0]  w_beat_data;

    // Unpack the flat data bus so the locked port can be picked by index.
    always_comb begin
        for (int p = 0; p < N_PORTS; p++) begin
            w_port_data[p] = i_rd_data[p*DATA_W +: DATA_W];
        end
    end

    // Only the locked port is observed; all others are ignored.
    assign w_beat_vld  = i_rd_vld[r_sel];
    assign w_beat_sop  = i_rd_sop[r_sel];
    assign w_beat_eop  = i_rd_eop[r_sel];
    assign w_beat_data = w_port_data[r_sel];

    // Next-state and beat-forwarding decisions.
    always_comb begin
        w_state_nxt    = r_state;
        w_sel_nxt      = r_sel;
        w_pend_nxt     = r_pend;
        w_pend_vld_nxt = r_pend_vld;
        w_timer_nxt    = r_timer;
        w_fwd          = 1'b0;
        w_fwd_sop      = 1'b0;
        w_fwd_eop      = 1'b0;
        w_perr         = 1'b0;
        w_tmo          = 1'b0;
        w_close        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_sel_vld) begin
                    w_sel_nxt   = i_sel;
                    w_timer_nxt = '0;
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (w_beat_vld && w_beat_sop) begin
                    w_fwd     = 1'b1;
                    w_fwd_sop = 1'b1;
                    w_fwd_eop = w_beat_eop;
                    if (w_beat_eop) begin
                        w_close = 1'b1;
                    end else begin
                        w_state_nxt = ST_XFER;
                        // The packet has started: a new select must wait for its end.
                        if (i_sel_vld) begin
                            w_pend_nxt     = i_sel;
                            w_pend_vld_nxt = 1'b1;
                        end
                    end
                end else begin
                    if (w_beat_vld) begin
                        w_perr = 1'b1;
                    end
                    if (i_sel_vld) begin
                        w_sel_nxt   = i_sel;
                        w_timer_nxt = '0;
                    end else if (r_timer == TMR_LAST) begin
                        w_tmo       = 1'b1;
                        w_timer_nxt = '0;
                        w_state_nxt = ST_IDLE;
                    end else if (r_timer != '1) begin
                        w_timer_nxt = r_timer + 1'b1;
                    end
                end
            end
            ST_XFER: begin
                if (w_beat_vld) begin
                    w_fwd     = 1'b1;
                    w_fwd_eop = w_beat_eop;
                    // A repeated sop mid-packet is passed on as a plain beat.
                    if (w_beat_sop) begin
                        w_perr = 1'b1;
                    end
                    if (w_beat_eop) begin
                        w_close = 1'b1;
                    end
                end
                if (!w_close && i_sel_vld) begin
                    w_pend_nxt     = i_sel;
                    w_pend_vld_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // End of packet: a select arriving with the closing beat wins over an older pending one.
        if (w_close) begin
            w_pend_vld_nxt = 1'b0;
            w_timer_nxt    = '0;
            if (i_sel_vld) begin
                w_sel_nxt   = i_sel;
                w_state_nxt = ST_ARMED;
            end else if (r_pend_vld) begin
                w_sel_nxt   = r_pend;
                w_state_nxt = ST_ARMED;
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end
    end

    // State and output registers; i_en low reloads the reset values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_sel       <= '0;
            r_pend      <= '0;
            r_pend_vld  <= 1'b0;
            r_timer     <= '0;
            r_busy      <= 1'b0;
            o_rd_sop    <= 1'b0;
            o_rd_eop    <= 1'b0;
            o_rd_vld    <= 1'b0;
            o_rd_data   <= '0;
            o_timeout   <= 1'b0;
            o_proto_err <= 1'b0;
        end else if (!i_en) begin
            r_state     <= ST_IDLE;
            r_sel       <= '0;
            r_pend      <= '0;
            r_pend_vld  <= 1'b0;
            r_timer     <= '0;
            r_busy      <= 1'b0;
            o_rd_sop    <= 1'b0;
            o_rd_eop    <= 1'b0;
            o_rd_vld    <= 1'b0;
            o_rd_data   <= '0;
            o_timeout   <= 1'b0;
            o_proto_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sel       <= w_sel_nxt;
            r_pend      <= w_pend_nxt;
            r_pend_vld  <= w_pend_vld_nxt;
            r_timer     <= w_timer_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
            o_rd_sop    <= w_fwd_sop;
            o_rd_eop    <= w_fwd_eop;
            o_rd_vld    <= w_fwd;
            o_timeout   <= w_tmo;
            o_proto_err <= w_perr;
            if (w_fwd) begin
                o_rd_data <= w_beat_data;
            end
        end
    end

    assign o_sel  = r_sel;
    assign o_busy = r_busy;

endmodule
